axis_dest_scheduler: RTL and testbench

// Transmit-side packet scheduler feeding one crossbar slave port (s*_tdata/tdest/tlast).

---
 rtl/axis_dest_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_axis_dest_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dest_scheduler.sv
// rtl/axis_dest_scheduler.sv - round-robin per-packet tdest assignment with output register and skid buffer
// Optional per-destination credit flow control is compiled in with `define SCHED_CREDIT_EN.
module axis_dest_scheduler #(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_DEST_WIDTH = 9,
    parameter int NUM_DEST        = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [AXIS_DEST_WIDTH-1:0] m_axis_tdest,
    input  logic [NUM_DEST-1:0]        dest_done,
    output logic                       credit_err
);
    localparam int IW = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, BUSY} state_t;

    state_t                     state_q, state_d;
    logic                       ready_q, ready_d;
    logic [AXIS_DEST_WIDTH-1:0] cur_dest_q, cur_dest_d;
    logic [AXIS_DEST_WIDTH-1:0] last_dest_q, last_dest_d;
    logic [AXIS_DEST_WIDTH-1:0] pick_dest, beat_dest;
    logic [NUM_DEST-1:0]        elig_q, elig_next;
    logic                       accept, out_free;

    logic                       out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [AXIS_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [AXIS_KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
    logic [AXIS_DEST_WIDTH-1:0] out_dest_q, out_dest_d;
    logic                       skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
    logic [AXIS_DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [AXIS_KEEP_WIDTH-1:0] skid_keep_q, skid_keep_d;
    logic [AXIS_DEST_WIDTH-1:0] skid_dest_q, skid_dest_d;

    assign accept    = s_axis_tvalid && ready_q;
    assign out_free  = !out_valid_q || m_axis_tready;
    assign beat_dest = (state_q == BUSY) ? cur_dest_q : pick_dest;

    // Rotating scan starting just after the destination used by the previous packet.
    always_comb begin
        int  idx;
        logic found;
        pick_dest = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_DEST; i++) begin
            idx = int'(last_dest_q) + i;
            if (idx >= NUM_DEST) idx = idx - NUM_DEST;
            if (!found && elig_q[IW'(idx)]) begin
                pick_dest = AXIS_DEST_WIDTH'(idx);
                found     = 1'b1;
            end
        end
    end

`ifdef SCHED_CREDIT_EN
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    logic [CW-1:0] credit_q [NUM_DEST];
    logic [CW-1:0] credit_d [NUM_DEST];
    logic          credit_err_q, credit_err_d;
    logic          first_beat;

    assign first_beat = accept && (state_q != BUSY);

    // A grant and a completion on the same destination in one cycle cancel out.
    always_comb begin
        credit_err_d = credit_err_q;
        for (int d = 0; d < NUM_DEST; d++) begin
            credit_d[d] = credit_q[d];
            if (dest_done[d] && !(first_beat && pick_dest == AXIS_DEST_WIDTH'(d))) begin
                if (credit_q[d] == CW'(MAX_OUTSTANDING)) credit_err_d = 1'b1;
                else                                     credit_d[d] = credit_q[d] + 1'b1;
            end else if (!dest_done[d] && first_beat && pick_dest == AXIS_DEST_WIDTH'(d)) begin
                credit_d[d] = credit_q[d] - 1'b1;
            end
            elig_q[d]    = (credit_q[d] != '0);
            elig_next[d] = (credit_d[d] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < NUM_DEST; d++) credit_q[d] <= CW'(MAX_OUTSTANDING);
            credit_err_q <= 1'b0;
        end else begin
            for (int d = 0; d < NUM_DEST; d++) credit_q[d] <= credit_d[d];
            credit_err_q <= credit_err_d;
        end
    end

    assign credit_err = credit_err_q;
`else
    logic unused_dest_done;
    assign unused_dest_done = ^dest_done;
    assign elig_q           = '1;
    assign elig_next        = '1;
    assign credit_err       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cur_dest_d  = cur_dest_q;
        last_dest_d = last_dest_q;
        case (state_q)
            IDLE, WAIT: begin
                if (accept) begin
                    cur_dest_d  = pick_dest;
                    last_dest_d = pick_dest;
                    state_d     = s_axis_tlast ? IDLE : BUSY;
                end else if (state_q == IDLE && s_axis_tvalid && !(|elig_q)) begin
                    state_d = WAIT;
                end else if (state_q == WAIT && (|elig_q)) begin
                    state_d = IDLE;
                end
            end
            BUSY: if (accept && s_axis_tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_dest_d   = out_dest_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;
        skid_keep_d  = skid_keep_q;
        skid_dest_d  = skid_dest_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_last_d   = skid_last_q;
                out_data_d   = skid_data_q;
                out_keep_d   = skid_keep_q;
                out_dest_d   = skid_dest_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_last_d  = s_axis_tlast;
                out_data_d  = s_axis_tdata;
                out_keep_d  = s_axis_tkeep;
                out_dest_d  = beat_dest;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_last_d  = s_axis_tlast;
            skid_data_d  = s_axis_tdata;
            skid_keep_d  = s_axis_tkeep;
            skid_dest_d  = beat_dest;
        end
        // Ready is held low at a packet boundary while no destination has credit.
        ready_d = !skid_valid_d && ((state_d == BUSY) || (|elig_next));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            cur_dest_q   <= '0;
            last_dest_q  <= AXIS_DEST_WIDTH'(NUM_DEST - 1);
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_dest_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_keep_q  <= '0;
            skid_dest_q  <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            cur_dest_q   <= cur_dest_d;
            last_dest_q  <= last_dest_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_dest_q   <= out_dest_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
            skid_data_q  <= skid_data_d;
            skid_keep_q  <= skid_keep_d;
            skid_dest_q  <= skid_dest_d;
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tdest  = out_dest_q;

endmodule

// File: tb/tb_axis_dest_scheduler.sv
// tb/tb_axis_dest_scheduler.sv - randomized self-checking bench for axis_dest_scheduler
module tb_axis_dest_scheduler;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int TW = 9;
    localparam int ND = 3;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [TW-1:0] m_axis_tdest;
    logic [ND-1:0] dest_done = '0;
    logic          credit_err;

    axis_dest_scheduler #(
        .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_DEST_WIDTH(TW),
        .NUM_DEST(ND), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
        .dest_done(dest_done), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        int            dest;
    } beat_t;

    beat_t exp_q[$];
    int    obs_dest[$];
    int    obs_len[$];
    int    m_credit[ND];
    int    m_last;
    int    m_cur;
    bit    m_in_pkt;
    bit    m_err;
    bit    m_out_first;
    bit    rst_prev;
    int    n_checks = 0;
    int    n_fail = 0;

    int            mready_mode = 0;
    bit            rand_done = 1'b0;
    logic [ND-1:0] dd_force = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: packet-level round robin over destinations holding credit.
    always @(negedge clk) begin
        beat_t b;
        int    p;
        int    c;
        bit    any;
        if (rst) begin
            if (rst_prev) check("tready_in_reset", s_axis_tready, 0);
            exp_q.delete();
            for (int d = 0; d < ND; d++) m_credit[d] = MO;
            m_last      = ND - 1;
            m_cur       = 0;
            m_in_pkt    = 1'b0;
            m_err       = 1'b0;
            m_out_first = 1'b1;
        end else begin
            check("credit_err", credit_err, m_err);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    check("tdata", m_axis_tdata, b.data);
                    check("tkeep", m_axis_tkeep, b.keep);
                    check("tlast", m_axis_tlast, b.last);
                    check("tdest", m_axis_tdest, b.dest);
                end
                if (m_out_first) begin
                    obs_dest.push_back(int'(m_axis_tdest));
                    obs_len.push_back(0);
                end
                obs_len[obs_len.size()-1] += 1;
                m_out_first = m_axis_tlast;
            end
`ifdef SCHED_CREDIT_EN
            any = 1'b0;
            for (int d = 0; d < ND; d++) if (m_credit[d] > 0) any = 1'b1;
            if (!m_in_pkt && s_axis_tvalid && !any) check("tready_no_credit", s_axis_tready, 0);
`endif
            if (s_axis_tvalid && s_axis_tready) begin
                if (!m_in_pkt) begin
                    p = -1;
                    for (int i = 1; i <= ND; i++) begin
                        c = (m_last + i) % ND;
`ifdef SCHED_CREDIT_EN
                        if (p < 0 && m_credit[c] > 0) p = c;
`else
                        if (p < 0) p = c;
`endif
                    end
                    if (p < 0) begin
                        check("accept_without_credit", 1, 0);
                        p = (m_last + 1) % ND;
                    end
`ifdef SCHED_CREDIT_EN
                    m_credit[p] -= 1;
`endif
                    m_last = p;
                    m_cur  = p;
                end
                b.data = s_axis_tdata;
                b.keep = s_axis_tkeep;
                b.last = s_axis_tlast;
                b.dest = m_cur;
                exp_q.push_back(b);
                m_in_pkt = !s_axis_tlast;
            end
`ifdef SCHED_CREDIT_EN
            for (int d = 0; d < ND; d++) begin
                if (dest_done[d]) begin
                    if (m_credit[d] >= MO) m_err = 1'b1;
                    else                   m_credit[d] += 1;
                end
            end
`endif
        end
        rst_prev = rst;
    end

    // Sole driver of m_axis_tready and dest_done.
    initial begin
        bit tog = 1'b0;
        int d;
        forever begin
            @(posedge clk);
            #2;
            case (mready_mode)
                1:       m_axis_tready = 1'($urandom_range(0, 1));
                2:       begin m_axis_tready = !tog; tog = !tog; end
                default: begin m_axis_tready = 1'b1; tog = 1'b0; end
            endcase
            dest_done = dd_force;
            if (rand_done && $urandom_range(0, 7) == 0) begin
                d = $urandom_range(0, ND - 1);
                if (m_credit[d] < MO) dest_done[d] = 1'b1;
            end
        end
    end

    task automatic send_beat(input bit last);
        bit hs;
        int cyc;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {$urandom, $urandom};
        s_axis_tkeep  = KW'($urandom);
        s_axis_tlast  = last;
        hs  = 1'b0;
        cyc = 0;
        while (!hs && cyc < 300) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!hs) check("s_handshake_timeout", hs, 1);
    endtask

    task automatic send_pkt(input int len, input int gap_max);
        for (int i = 0; i < len; i++) begin
            send_beat(i == len - 1);
            if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                repeat ($urandom_range(1, gap_max)) @(posedge clk);
                #1;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdest", m_axis_tdest, 0);
        check("rst_credit_err", credit_err, 0);
        @(negedge clk);
        check("ready_after_reset", s_axis_tready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  base;
        bit  seen;
        int  exp13;
        // Single-beat packets: rotation from dest 0 and one-cycle latency.
        do_reset();
        base = obs_dest.size();
        for (int i = 0; i < 4; i++) begin
            send_pkt(1, 0);
            @(negedge clk);
            check("t1_latency_tvalid", m_axis_tvalid, 1);
            @(posedge clk);
            #1;
        end
        drain();
        for (int i = 0; i < 4; i++) check("t1_dest", obs_dest[base+i], (i == 3) ? 0 : i);

        // Multi-beat packet under alternating backpressure.
        do_reset();
        mready_mode = 2;
        base = obs_dest.size();
        send_pkt(4, 0);
        drain();
        check("t2_dest", obs_dest[base], 0);
        check("t2_len", obs_len[base], 4);
        mready_mode = 0;

        // Credit exhaustion and release by dest_done[1].
        do_reset();
        base = obs_dest.size();
        for (int i = 0; i < 12; i++) send_pkt(1, 0);
        drain();
        for (int i = 0; i < 12; i++) check("t3_dest", obs_dest[base+i], i % 3);
`ifdef SCHED_CREDIT_EN
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= s_axis_tready;
            @(posedge clk);
            #1;
        end
        check("t3_stall", seen, 0);
        s_axis_tvalid = 1'b0;
        dd_force = 3'b010;
        @(posedge clk);
        #1;
        dd_force = '0;
        exp13 = 1;
`else
        exp13 = 0;
`endif
        send_pkt(1, 0);
        drain();
        check("t3_dest13", obs_dest[base+12], exp13);

        // Reset in the middle of a packet.
        do_reset();
        send_beat(1'b0);
        send_beat(1'b0);
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_tvalid_after_rst", m_axis_tvalid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        base = obs_dest.size();
        send_pkt(2, 0);
        drain();
        check("t5_dest", obs_dest[base], 0);

        // dest_done at full credit.
        do_reset();
        dd_force = 3'b100;
        @(posedge clk);
        #1;
        dd_force = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
`ifdef SCHED_CREDIT_EN
        check("t6_credit_err", credit_err, 1);
`else
        check("t6_credit_err", credit_err, 0);
`endif
        @(posedge clk);
        #1;

        // Randomized traffic with backpressure and credit returns.
        do_reset();
        mready_mode = 1;
        rand_done   = 1'b1;
        for (int i = 0; i < 150; i++) send_pkt($urandom_range(1, 4), 2);
        mready_mode = 0;
        drain();
        rand_done = 1'b0;
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
